// File: rtl/rv32i_types.sv
// Shared RV32I core types; cdb_entry_t is what a functional unit broadcasts on the CDB.
package rv32i_types;
    typedef struct packed {
        logic [4:0]  rob_idx;
        logic [4:0]  rd;
        logic [31:0] value;
    } cdb_entry_t;
endpackage

// File: rtl/fu_cdb_buffer.sv
// Per-FU writeback queue in front of the CDB arbiter: in-order results, pop on grant,
// full flush on branch mispredict, combinational stall that honours a same-cycle pop.
module fu_cdb_buffer
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fu_valid,
    input  cdb_entry_t                 fu_result,
    output logic                       fu_stall,
    output cdb_entry_t                 cdb_value,
    output logic                       fu_ready,
    input  logic                       select,
    input  logic                       branch_mispredict,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    cdb_entry_t    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign pop  = select && !empty;
    assign push = fu_valid && (!full || pop);

    // Outputs depend only on registered state and select, never on fu_valid.
    assign fu_stall  = full && !select;
    assign fu_ready  = !empty;
    assign cdb_value = empty ? '0 : mem[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (branch_mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)
                head <= head + PW'(1);
            if (push)
                tail <= tail + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Storage carries no reset; stale slots are masked by empty.
    always_ff @(posedge clk) begin
        if (push && !branch_mispredict)
            mem[tail] <= fu_result;
    end
endmodule

// File: tb/tb_fu_cdb_buffer.sv
// Bench for fu_cdb_buffer: directed scenarios then random traffic, all checked
// against a queue model of the writeback buffer.
module tb_fu_cdb_buffer;
    import rv32i_types::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fu_valid;
    cdb_entry_t    fu_result;
    logic          fu_stall;
    cdb_entry_t    cdb_value;
    logic          fu_ready;
    logic          select;
    logic          branch_mispredict;
    logic [CW-1:0] count;

    int tests_run = 0;
    int tests_failed = 0;

    cdb_entry_t model_q[$];

    fu_cdb_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fu_valid(fu_valid),
        .fu_result(fu_result),
        .fu_stall(fu_stall),
        .cdb_value(cdb_value),
        .fu_ready(fu_ready),
        .select(select),
        .branch_mispredict(branch_mispredict),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic cdb_entry_t mk(input logic [31:0] v);
        cdb_entry_t e;
        e.rob_idx = 5'($urandom);
        e.rd      = 5'($urandom);
        e.value   = v;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        cdb_entry_t exp_val;
        exp_val = (model_q.size() == 0) ? '0 : model_q[0];
        chk({tag, ".count"}, 64'(count), 64'(model_q.size()));
        chk({tag, ".ready"}, 64'(fu_ready), 64'(model_q.size() != 0));
        chk({tag, ".value"}, 64'(cdb_value), 64'(exp_val));
        chk({tag, ".stall"}, 64'(fu_stall), 64'((model_q.size() == DEPTH) && !select));
    endtask

    // Starts and ends at a falling edge; outputs checked before the rising edge.
    task automatic cycle(input string tag, input logic v, input logic [31:0] val,
                         input logic sel, input logic bm);
        cdb_entry_t e;
        bit was_full;
        bit popped;
        e = mk(val);
        fu_valid = v;
        fu_result = e;
        select = sel;
        branch_mispredict = bm;
        #1;
        chk_outputs(tag);
        @(posedge clk);
        if (bm) begin
            model_q.delete();
        end else begin
            was_full = (model_q.size() == DEPTH);
            popped = 1'b0;
            if (sel && model_q.size() != 0) begin
                void'(model_q.pop_front());
                popped = 1'b1;
            end
            if (v && (!was_full || popped))
                model_q.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        fu_valid = 1'b0;
        fu_result = '0;
        select = 1'b0;
        branch_mispredict = 1'b0;
        repeat (2) @(negedge clk);
        chk_outputs("reset");
        rst_n = 1'b1;

        // single result
        cycle("single_push", 1'b1, 32'h11, 1'b0, 1'b0);
        chk("single_visible", 64'(cdb_value.value), 64'h11);
        cycle("single_pop", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("single_after", 1'b0, 32'h0, 1'b0, 1'b0);

        // fill, stall, dropped push
        for (int i = 0; i < 4; i++)
            cycle("fill", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        cycle("full_drop", 1'b1, 32'hA4, 1'b0, 1'b0);
        chk("full_head", 64'(cdb_value.value), 64'hA0);
        chk("full_stall", 64'(fu_stall), 64'h1);

        // push while popping at full, then drain across wrap
        cycle("full_pushpop", 1'b1, 32'hB0, 1'b1, 1'b0);
        chk("fpp_head", 64'(cdb_value.value), 64'hA1);
        for (int i = 0; i < 4; i++)
            cycle("drain", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("drained", 1'b0, 32'h0, 1'b0, 1'b0);

        // streaming
        for (int i = 1; i <= 10; i++)
            cycle("stream", 1'b1, 32'(i), 1'b1, 1'b0);
        chk("stream_last", 64'(cdb_value.value), 64'd10);
        cycle("stream_drain", 1'b0, 32'h0, 1'b1, 1'b0);

        // flush with simultaneous push and pop
        for (int i = 0; i < 3; i++)
            cycle("pre_flush", 1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'hC0, 1'b1, 1'b1);
        cycle("post_flush", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_value", 64'(cdb_value), 64'h0);

        // spurious grants
        for (int i = 0; i < 3; i++)
            cycle("spurious", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("push_d0", 1'b1, 32'hD0, 1'b0, 1'b0);
        chk("d0_value", 64'(cdb_value.value), 64'hD0);
        cycle("pop_d0", 1'b0, 32'h0, 1'b1, 1'b0);

        // asynchronous reset mid-cycle with entries queued
        for (int i = 0; i < 3; i++)
            cycle("pre_reset", 1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
        fu_valid = 1'b0;
        select = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        chk_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("after_reset", 1'b1, 32'hF0, 1'b0, 1'b0);
        cycle("after_reset_pop", 1'b0, 32'h0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++)
            cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        cycle("final", 1'b0, 32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
